// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizing helpers for the mux scan sequencer.
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_nto1.sv
// Combinational N:1 slice select; yields zero for select codes beyond CHANNELS-1.
module mux_nto1 #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          y_c
);

  always_comb begin
    y_c = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) y_c = data_in[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Registered N:1 mux with manual select and auto-scan with programmable dwell.
// Optional MUX_SKIP_MASK_EN adds a skip_mask port that removes channels from the scan.
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
`ifdef MUX_SKIP_MASK_EN
  input  logic [CHANNELS-1:0]       skip_mask,
`endif
  output logic [WIDTH-1:0]          y,
  output logic [SEL_W-1:0]          sel_out,
  output logic                      valid,
  output logic                      wrap
);

  localparam int unsigned      DWELL_W    = cnt_w(DWELL);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   LAST_CH    = SEL_W'(CHANNELS - 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d, start_ch;
  logic [WIDTH-1:0]     y_q, y_d, mux_y_c;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;
  logic                 scan_live_c;

  function automatic logic in_range(input logic [SEL_W-1:0] ch);
    return 32'(ch) < CHANNELS;
  endfunction

`ifdef MUX_SKIP_MASK_EN
  function automatic logic is_masked(input logic [SEL_W-1:0] ch,
                                     input logic [CHANNELS-1:0] m);
    logic r;
    r = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch == SEL_W'(k)) r = m[k];
    end
    return r;
  endfunction

  // Next unmasked channel in ascending order, modulo CHANNELS.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch,
                                               input logic [CHANNELS-1:0] m);
    logic [SEL_W-1:0] r;
    logic             found;
    int unsigned      idx;
    r     = ch;
    found = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (32'(ch) + i) % CHANNELS;
      if (!found && !m[idx]) begin
        r     = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign scan_live_c = !(&skip_mask);
`else
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
  endfunction

  assign scan_live_c = 1'b1;
`endif

  // Select path: state, dwell counter, channel position and wrap pulse.
  always_comb begin
    state_d  = ST_IDLE;
    sel_d    = sel_q;
    dwell_d  = '0;
    wrap_d   = 1'b0;
    start_ch = in_range(sel_q) ? sel_q : '0;
    if (en && !mode) begin
      state_d = ST_MANUAL;
      sel_d   = sel_in;
    end else if (en) begin
      state_d = ST_SCAN;
`ifdef MUX_SKIP_MASK_EN
      if (scan_live_c) begin
        if (state_q != ST_SCAN) begin
          sel_d  = is_masked(start_ch, skip_mask) ? next_ch(start_ch, skip_mask) : start_ch;
          wrap_d = (sel_d < start_ch);
        end else if (dwell_q == DWELL_LAST) begin
          sel_d  = next_ch(sel_q, skip_mask);
          wrap_d = (sel_d < sel_q);
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
`else
      if (state_q != ST_SCAN) begin
        sel_d = start_ch;
      end else if (dwell_q == DWELL_LAST) begin
        sel_d  = next_ch(sel_q);
        wrap_d = (sel_q == LAST_CH);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
`endif
    end
  end

  mux_nto1 #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_mux (
    .data_in (data_in),
    .sel     (sel_d),
    .y_c     (mux_y_c)
  );

  // Data path: y follows the channel selected for the coming cycle.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (state_d == ST_MANUAL) begin
      y_d     = mux_y_c;
      valid_d = in_range(sel_d);
    end else if (state_d == ST_SCAN && scan_live_c) begin
      y_d     = mux_y_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      y_q     <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y       = y_q;
  assign sel_out = sel_q;
  assign valid   = valid_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: behavioural scan model plus directed literal checks on two configurations.
module tb_mux_scan_sequencer;

  localparam int unsigned W   = 4;
  localparam int unsigned CH  = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned DW  = 4;
  localparam int unsigned CH6 = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic [SW-1:0] sel_in = '0;
  int ch [CH];
  logic [CH*W-1:0] data_in;
`ifdef MUX_SKIP_MASK_EN
  logic [CH-1:0] skip_mask = '0;
`endif

  logic [W-1:0]  y, y6;
  logic [SW-1:0] sel_out, sel6;
  logic          valid, valid6, wrap, wrap6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < CH; k++) data_in[k*W +: W] = W'(ch[k]);
  end

  mux_scan_sequencer #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .data_in(data_in),
`ifdef MUX_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .y(y), .sel_out(sel_out), .valid(valid), .wrap(wrap)
  );

  mux_scan_sequencer #(.WIDTH(W), .CHANNELS(CH6), .SEL_W(SW), .DWELL(1)) dut6 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in),
    .data_in(data_in[CH6*W-1:0]),
`ifdef MUX_SKIP_MASK_EN
    .skip_mask(skip_mask[CH6-1:0]),
`endif
    .y(y6), .sel_out(sel6), .valid(valid6), .wrap(wrap6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Behavioural model of the 8-channel, dwell-4 instance.
  int m_y = 0, m_sel = 0, m_age = 0;
  bit m_valid = 0, m_wrap = 0, m_scan = 0, m_known = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_y = 0; m_sel = 0; m_age = 0;
      m_valid = 0; m_wrap = 0; m_scan = 0; m_known = 1;
    end else if (!en) begin
      m_valid = 0; m_wrap = 0; m_scan = 0;
    end else if (!mode) begin
      m_scan = 0; m_wrap = 0;
      m_sel = int'(sel_in);
      m_valid = (m_sel < CH);
      m_y = m_valid ? ch[m_sel] : 0;
    end else begin
      m_wrap = 0;
      if (!m_scan) begin
        if (m_sel >= CH) m_sel = 0;
        m_age = 0;
        m_scan = 1;
      end else begin
        m_age = m_age + 1;
        if (m_age == DW) begin
          m_age = 0;
          m_sel = (m_sel + 1) % CH;
          m_wrap = (m_sel == 0);
        end
      end
      m_y = ch[m_sel];
      m_valid = 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_y",     32'(y),       32'(m_y));
      check("model_sel",   32'(sel_out), 32'(m_sel));
      check("model_valid", 32'(valid),   32'(m_valid));
      check("model_wrap",  32'(wrap),    32'(m_wrap));
    end
  end

  initial begin
    for (int k = 0; k < CH; k++) ch[k] = k + 1;
    tick(); tick();

    // Reset held two cycles in the middle of an active scan.
    reset = 1'b0; en = 1'b1; mode = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("rst_y", 32'(y), 0);
    check("rst_sel", 32'(sel_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_wrap", 32'(wrap), 0);
    tick();
    reset = 1'b0;

    // Scan from channel 0: four cycles per channel, wrap after channel 7.
    for (int i = 0; i <= 32; i++) begin
      tick();
      check("scan_sel", 32'(sel_out), 32'((i / 4) % 8));
      check("scan_y", 32'(y), 32'((i / 4) % 8 + 1));
      check("scan_wrap", 32'(wrap), 32'(i == 32));
      check("scan6_sel", 32'(sel6), 32'(i % 6));
      check("scan6_wrap", 32'(wrap6), 32'(i > 0 && i % 6 == 0));
    end

    // Manual select, including an out-of-range code on the 6-channel instance.
    mode = 1'b0; sel_in = 3'd5;
    tick();
    check("man_y", 32'(y), 6);
    check("man_valid", 32'(valid), 1);
    check("man_sel", 32'(sel_out), 5);
    check("man6_y", 32'(y6), 6);
    sel_in = 3'd7;
    tick();
    check("man_y7", 32'(y), 8);
    check("man6_oor_y", 32'(y6), 0);
    check("man6_oor_valid", 32'(valid6), 0);
    check("man6_oor_sel", 32'(sel6), 7);

    // Scan entry: 8-ch keeps channel 7, 6-ch restarts at 0.
    mode = 1'b1;
    tick();
    check("entry_sel", 32'(sel_out), 7);
    check("entry6_sel", 32'(sel6), 0);
    check("entry6_y", 32'(y6), 1);
    check("entry6_valid", 32'(valid6), 1);

    // Mode change at dwell expiry on channel 7: no advance, no wrap.
    repeat (3) tick();
    check("pre_exp_sel", 32'(sel_out), 7);
    mode = 1'b0; sel_in = 3'd2;
    tick();
    check("modechg_sel", 32'(sel_out), 2);
    check("modechg_wrap", 32'(wrap), 0);
    check("modechg_y", 32'(y), 3);

    // Enable pause at channel 3 with two dwell cycles spent.
    mode = 1'b1;
    tick();
    repeat (6) tick();
    check("pause_pre_sel", 32'(sel_out), 3);
    en = 1'b0;
    repeat (2) begin
      tick();
      check("pause_valid", 32'(valid), 0);
      check("pause_sel", 32'(sel_out), 3);
      check("pause_wrap", 32'(wrap), 0);
    end
    en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("resume_sel", 32'(sel_out), 3);
      check("resume_valid", 32'(valid), 1);
    end
    tick();
    check("resume_adv", 32'(sel_out), 4);

    // Randomised traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < CH; k++) ch[k] = int'($urandom_range(0, 15));
      sel_in = SW'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      en = ($urandom_range(0, 24) != 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
